// File: rtl/procyon_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// procyon_fifo_wr_arb
//
// Round-robin write arbiter that shares a single procyon_sync_fifo write port
// among OPTN_NUM_REQ requesters. A multi-beat burst locks the port to its
// owner until the last beat is written, so bursts never interleave in the FIFO.
// Grant/ack is combinational from registered arbiter state and the FIFO full
// flag; a beat is only written when the FIFO can take it.
//
// Ports:
//   clk          clock, all state updates on posedge
//   n_rst        synchronous active-low reset
//   i_flush      abort any burst, return to IDLE (rr pointer kept)
//   i_req_valid  per-requester beat valid
//   i_req_data   per-requester beat data, requester k at [k*W +: W]
//   i_req_last   per-requester final-beat flag
//   o_req_ack    one-hot, beat of requester k consumed this cycle
//   o_fifo_we    FIFO write enable
//   o_fifo_data  FIFO write data
//   i_fifo_full  FIFO full flag (registered inside the FIFO)
// -----------------------------------------------------------------------------
module procyon_fifo_wr_arb #(
   parameter int OPTN_DATA_WIDTH = 8,
   parameter int OPTN_NUM_REQ    = 4
) (
   input  logic                                    clk,
   input  logic                                    n_rst,
   input  logic                                    i_flush,
   input  logic [OPTN_NUM_REQ-1:0]                 i_req_valid,
   input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0] i_req_data,
   input  logic [OPTN_NUM_REQ-1:0]                 i_req_last,
   output logic [OPTN_NUM_REQ-1:0]                 o_req_ack,
   output logic                                    o_fifo_we,
   output logic [OPTN_DATA_WIDTH-1:0]              o_fifo_data,
   input  logic                                    i_fifo_full
);

   localparam int PTR_W = $clog2(OPTN_NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(OPTN_NUM_REQ - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [PTR_W-1:0] r_owner;
   logic [PTR_W-1:0] w_owner_next;
   logic [PTR_W-1:0] r_rr_ptr;
   logic [PTR_W-1:0] w_rr_ptr_next;

   logic [PTR_W-1:0] w_search_idx;
   logic             w_search_valid;
   logic [PTR_W-1:0] w_cand;
   logic             w_cand_valid;
   logic             w_accept;

   // Explicit wrap so non-power-of-2 requester counts stay in range.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search: first valid requester starting at r_rr_ptr.
   // NOTE: every variable written here gets a default first so no latch is
   // inferred; blocking assignments are correct inside combinational blocks.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_search_valid = 1'b0;
      w_search_idx   = r_rr_ptr;
      w_idx          = r_rr_ptr;
      for (int i = 0; i < OPTN_NUM_REQ; i++) begin
         if (!w_search_valid && i_req_valid[w_idx]) begin
            w_search_valid = 1'b1;
            w_search_idx   = w_idx;
         end
         w_idx = ptr_inc(w_idx);
      end
   end

   // While locked only the owner may write; a missing owner beat is a bubble.
   assign w_cand       = (r_state == LOCKED) ? r_owner : w_search_idx;
   assign w_cand_valid = (r_state == LOCKED) ? i_req_valid[r_owner] : w_search_valid;
   assign w_accept     = n_rst & ~i_flush & ~i_fifo_full & w_cand_valid;

   assign o_fifo_we   = w_accept;
   assign o_fifo_data = i_req_data[int'(w_cand)*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];

   always_comb begin
      o_req_ack = '0;
      if (w_accept) o_req_ack[w_cand] = 1'b1;
   end

   always_comb begin
      w_state_next  = r_state;
      w_owner_next  = r_owner;
      w_rr_ptr_next = r_rr_ptr;
      if (i_flush) begin
         w_state_next = IDLE;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            if (i_req_last[w_cand]) begin
               w_rr_ptr_next = ptr_inc(w_cand);
            end else begin
               w_state_next = LOCKED;
               w_owner_next = w_cand;
            end
         end else if (i_req_last[r_owner]) begin
            w_state_next  = IDLE;
            w_rr_ptr_next = ptr_inc(r_owner);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state  <= IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_next;
         r_owner  <= w_owner_next;
         r_rr_ptr <= w_rr_ptr_next;
      end
   end

endmodule
